// File: rtl/data_trans_pkg.sv
// Shared defaults and helpers for the Winograd front-end line buffer.
// Frame geometry, widths and the bank-age mapping used by data_trans_core.
package data_trans_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned IMG_W  = 640;
  localparam int unsigned IMG_H  = 360;
  localparam int unsigned RES_W  = 24;
  localparam int unsigned COL_AW = $clog2(IMG_W);
  localparam int unsigned ROW_AW = $clog2(IMG_H);

  // Bank holding the row 'age' rows older than the row in bank 'cur'.
  function automatic logic [1:0] older_bank(input logic [1:0] cur, input logic [1:0] age);
    return cur - age;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line bank: one synchronous write port, one registered read port.
// Contents are not reset.
module line_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_trans_core.sv
// 4-row line buffer and 4x4 window accumulator. Each accepted pixel from row 3 onward
// emits its 4-pixel column (oldest row first) and the sum of the 4x4 window ending there.
module data_trans_core #(
  parameter int unsigned DW    = data_trans_pkg::DW,
  parameter int unsigned IMG_W = data_trans_pkg::IMG_W,
  parameter int unsigned IMG_H = data_trans_pkg::IMG_H,
  parameter int unsigned RES_W = data_trans_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_valid,
  input  logic [DW-1:0]    data_in,
  output logic             output_valid,
  output logic [DW-1:0]    ram_out_0,
  output logic [DW-1:0]    ram_out_1,
  output logic [DW-1:0]    ram_out_2,
  output logic [DW-1:0]    ram_out_3,
  output logic [RES_W-1:0] result
);
  import data_trans_pkg::*;

  localparam int unsigned CAW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RAW = (IMG_H > 4) ? $clog2(IMG_H) : 2;

  typedef logic [3:0][DW-1:0] col_vec_t;

  logic [CAW-1:0] col_q;
  logic [RAW-1:0] row_q;

  // Capture register: pixel plus its coordinates, sampled with the counters.
  logic           s0_valid_q, s0_out_q, s0_first_q;
  logic [DW-1:0]  s0_pix_q;
  logic [CAW-1:0] s0_col_q;
  logic [1:0]     s0_bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_out_q   <= 1'b0;
      s0_first_q <= 1'b0;
      s0_pix_q   <= '0;
      s0_col_q   <= '0;
      s0_bank_q  <= '0;
    end else begin
      s0_valid_q <= input_valid;
      s0_out_q   <= input_valid && (row_q >= RAW'(3));
      if (input_valid) begin
        s0_pix_q   <= data_in;
        s0_col_q   <= col_q;
        s0_bank_q  <= row_q[1:0];
        s0_first_q <= (col_q == '0);
        if (col_q == CAW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RAW'(IMG_H - 1)) ? '0 : row_q + RAW'(1);
        end else begin
          col_q <= col_q + CAW'(1);
        end
      end
    end
  end

  // Stage 1: write the pixel to its bank and read all banks at the same column.
  // The written bank's read data is never used, so no read/write conflict matters.
  logic [DW-1:0] rd [4];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    line_ram #(
      .DW    (DW),
      .DEPTH (IMG_W),
      .AW    (CAW)
    ) u_line_ram (
      .clk   (clk),
      .we    (s0_valid_q && (s0_bank_q == 2'(b))),
      .waddr (s0_col_q),
      .wdata (s0_pix_q),
      .re    (s0_valid_q),
      .raddr (s0_col_q),
      .rdata (rd[b])
    );
  end

  logic          s1_out_q, s1_first_q;
  logic [DW-1:0] s1_pix_q;
  logic [1:0]    s1_bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_out_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_bank_q  <= '0;
    end else begin
      s1_out_q <= s0_out_q;
      if (s0_valid_q) begin
        s1_first_q <= s0_first_q;
        s1_pix_q   <= s0_pix_q;
        s1_bank_q  <= s0_bank_q;
      end
    end
  end

  // Stage 2: reorder banks by age, shift the window, sum 16 entries.
  col_vec_t win_q [3];
  col_vec_t new_col;
  col_vec_t prev_col [3];
  logic [RES_W-1:0] sum_d;

  always_comb begin
    new_col[0] = rd[older_bank(s1_bank_q, 2'd3)];
    new_col[1] = rd[older_bank(s1_bank_q, 2'd2)];
    new_col[2] = rd[older_bank(s1_bank_q, 2'd1)];
    new_col[3] = s1_pix_q;
    for (int i = 0; i < 3; i++) begin
      prev_col[i] = s1_first_q ? '0 : win_q[i];
    end
    sum_d = '0;
    for (int j = 0; j < 4; j++) begin
      sum_d = sum_d + RES_W'(new_col[j]);
      for (int i = 0; i < 3; i++) begin
        sum_d = sum_d + RES_W'(prev_col[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i] <= '0;
      end
      output_valid <= 1'b0;
      ram_out_0    <= '0;
      ram_out_1    <= '0;
      ram_out_2    <= '0;
      ram_out_3    <= '0;
      result       <= '0;
    end else begin
      output_valid <= s1_out_q;
      if (s1_out_q) begin
        win_q[0]  <= new_col;
        win_q[1]  <= prev_col[0];
        win_q[2]  <= prev_col[1];
        ram_out_0 <= new_col[0];
        ram_out_1 <= new_col[1];
        ram_out_2 <= new_col[2];
        ram_out_3 <= new_col[3];
        result    <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_data_trans_core.sv
// Scoreboard bench for data_trans_core on an 8x6 frame: directed frames, stall,
// mid-frame reset and a randomized stream, checked against a frame-array reference model.
module tb_data_trans_core;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 6;
  localparam int unsigned RES_W = 24;
  localparam int          LAT   = 3; // drive-cycle index to output edge index

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             input_valid = 1'b0;
  logic [7:0]       data_in = '0;
  logic             output_valid;
  logic [7:0]       ram_out_0, ram_out_1, ram_out_2, ram_out_3;
  logic [RES_W-1:0] result;

  data_trans_core #(
    .DW    (8),
    .IMG_W (W),
    .IMG_H (H),
    .RES_W (RES_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .data_in      (data_in),
    .output_valid (output_valid),
    .ram_out_0    (ram_out_0),
    .ram_out_1    (ram_out_1),
    .ram_out_2    (ram_out_2),
    .ram_out_3    (ram_out_3),
    .result       (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o0, o1, o2, o3;
    int         res;
    int         spec;
  } exp_t;

  exp_t       q[$];
  bit         exp_ov [2048];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         started = 0;

  logic [7:0] img [H][W];
  int         mr = 0;
  int         mc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: valid must match the predicted strobe pattern; data comes off the queue.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (output_valid !== exp_ov[cyc]) begin
        errors++;
        $display("FAIL valid_strobe cyc=%0d got=%b want=%b", cyc, output_valid, exp_ov[cyc]);
      end
      if (output_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got res=%0d want none", cyc, result);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (ram_out_0 !== e.o0 || ram_out_1 !== e.o1 || ram_out_2 !== e.o2 ||
              ram_out_3 !== e.o3 || result !== RES_W'(e.res)) begin
            errors++;
            $display("FAIL column_window cyc=%0d got %h %h %h %h res=%0d want %h %h %h %h res=%0d",
                     cyc, ram_out_0, ram_out_1, ram_out_2, ram_out_3, result,
                     e.o0, e.o1, e.o2, e.o3, e.res);
          end
          if (e.spec >= 0) begin
            checks++;
            if (result !== RES_W'(e.spec)) begin
              errors++;
              $display("FAIL known_sum cyc=%0d got=%0d want=%0d", cyc, result, e.spec);
            end
          end
        end
      end
    end
  end

  task automatic push_pix(input logic v, input logic [7:0] p, input int spec);
    @(posedge clk);
    #1;
    input_valid = v;
    data_in     = p;
    if (v) begin
      img[mr][mc] = p;
      if (mr >= 3) begin
        exp_t e;
        e.o0 = img[mr-3][mc];
        e.o1 = img[mr-2][mc];
        e.o2 = img[mr-1][mc];
        e.o3 = img[mr][mc];
        e.res = 0;
        for (int rr = mr - 3; rr <= mr; rr++) begin
          for (int cc = (mc >= 3) ? mc - 3 : 0; cc <= mc; cc++) begin
            e.res += int'(img[rr][cc]);
          end
        end
        e.spec = spec;
        q.push_back(e);
        exp_ov[cyc + LAT] = 1'b1;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    input_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = cyc; k < cyc + LAT + 1; k++) exp_ov[k] = 1'b0;
      q.delete();
      mr = 0;
      mc = 0;
      started = 1'b1;
      checks++;
      if (output_valid !== 1'b0 || ram_out_0 !== 8'h0 || ram_out_1 !== 8'h0 ||
          ram_out_2 !== 8'h0 || ram_out_3 !== 8'h0 || result !== '0) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d got v=%b %h %h %h %h res=%0d want all 0", cyc,
                 output_valid, ram_out_0, ram_out_1, ram_out_2, ram_out_3, result);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Frame 1: pixel = 16r+c, 5-cycle stall before (4,4).
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int spec;
        if (r == 4 && c == 4) repeat (5) push_pix(1'b0, 8'h00, -1);
        spec = (r == 3 && c == 0) ? 96 : (r == 3 && c == 3) ? 408 : (r == 4 && c == 0) ? 160 : -1;
        push_pix(1'b1, 8'(16 * r + c), spec);
      end
    end

    // Frame 2 (offset data) up to pixel (4,5), then a one-cycle reset instead.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 4 && c >= 5)) begin
          push_pix(1'b1, 8'(16 * r + c + 128), (r == 3 && c == 0) ? 608 : -1);
        end
      end
    end
    do_reset(1);

    // Randomized stream with idle gaps over several frames.
    for (int i = 0; i < 200; i++) begin
      push_pix(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)), -1);
    end
    repeat (6) push_pix(1'b0, 8'h00, -1);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
